// File: rtl/mul_div.sv
// mul_div: iterative 32-bit multiply/divide unit with HI/LO result registers.
//   CLK, Reset       : clock, synchronous active-high reset
//   Start, Op, A, B  : start request, op (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), operands
//   Write_HI/LO      : MTHI/MTLO strobes loading W_Data (ignored while iterating)
//   Busy             : operation iterating (32 cycles)
//   Done, Div_Zero   : one-cycle completion pulse; divide-by-zero flag in that cycle
//   HI, LO           : product high/low, or remainder/quotient
module mul_div (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Write_HI,
  input  logic        Write_LO,
  input  logic [31:0] W_Data,
  output logic        Busy,
  output logic        Done,
  output logic        Div_Zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e      r_state;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_sgn_diff;  // operand signs differ (signed ops only)
  logic        r_a_neg;     // dividend negative (signed ops only)
  logic        r_b_zero;
  logic [31:0] r_wh, r_wl;  // working accumulator, kept apart from HI/LO
  logic [31:0] r_opb;       // multiplicand or divisor magnitude
  logic        r_busy, r_done, r_dz;
  logic [31:0] r_hi, r_lo;

  logic        w_accept;
  logic [31:0] w_a_mag, w_b_mag;
  logic [32:0] w_sum, w_shift;
  logic [33:0] w_diff;
  logic [31:0] w_nh, w_nl;
  logic [63:0] w_prod, w_prod_s;
  logic [31:0] w_quo, w_rem, w_res_hi, w_res_lo;

  assign w_accept = Start && (r_state != StRun);
  assign w_a_mag  = (Op[0] && A[31]) ? -A : A;
  assign w_b_mag  = (Op[0] && B[31]) ? -B : B;

  // One iteration step: shift-add multiply or restoring divide.
  always_comb begin
    w_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opb} : 33'd0);
    w_shift = {r_wh, r_wl[31]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_opb};
    if (r_is_div) begin
      if (!w_diff[33]) begin
        w_nh = w_diff[31:0];
        w_nl = {r_wl[30:0], 1'b1};
      end else begin
        w_nh = w_shift[31:0];
        w_nl = {r_wl[30:0], 1'b0};
      end
    end else begin
      w_nh = w_sum[32:1];
      w_nl = {w_sum[0], r_wl[31:1]};
    end
  end

  // Sign fix-up applied to the final iteration's result.
  always_comb begin
    w_prod   = {w_nh, w_nl};
    w_prod_s = r_sgn_diff ? -w_prod : w_prod;
    // Divisor 0 drives every quotient bit to 1 and leaves |A| as remainder.
    w_quo    = r_b_zero ? 32'hFFFF_FFFF : (r_sgn_diff ? -w_nl : w_nl);
    w_rem    = r_a_neg ? -w_nh : w_nh;
    w_res_hi = r_is_div ? w_rem : w_prod_s[63:32];
    w_res_lo = r_is_div ? w_quo : w_prod_s[31:0];
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= StIdle;
      r_cnt      <= 5'd0;
      r_is_div   <= 1'b0;
      r_sgn_diff <= 1'b0;
      r_a_neg    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_wh       <= 32'd0;
      r_wl       <= 32'd0;
      r_opb      <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        StIdle, StFin: begin
          if (w_accept) begin
            // Start wins over a coincident MTHI/MTLO.
            r_state    <= StRun;
            r_cnt      <= 5'd0;
            r_busy     <= 1'b1;
            r_is_div   <= Op[1];
            r_sgn_diff <= Op[0] && (A[31] ^ B[31]);
            r_a_neg    <= Op[0] && A[31];
            r_b_zero   <= (B == 32'd0);
            r_wh       <= 32'd0;
            r_wl       <= Op[1] ? w_a_mag : w_b_mag;
            r_opb      <= Op[1] ? w_b_mag : w_a_mag;
          end else begin
            r_state <= StIdle;
            if (Write_HI) r_hi <= W_Data;
            if (Write_LO) r_lo <= W_Data;
          end
        end
        StRun: begin
          r_wh  <= w_nh;
          r_wl  <= w_nl;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= StFin;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_dz    <= r_is_div && r_b_zero;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Div_Zero = r_dz;
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule

// File: tb/tb_mul_div.sv
// tb_mul_div: randomized scoreboard bench for mul_div against an arithmetic reference model.
module tb_mul_div;

  logic        CLK = 1'b0;
  logic        Reset, Start, Write_HI, Write_LO;
  logic [1:0]  Op;
  logic [31:0] A, B, W_Data;
  logic        Busy, Done, Div_Zero;
  logic [31:0] HI, LO;

  mul_div dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Write_HI (Write_HI),
    .Write_LO (Write_LO),
    .W_Data   (W_Data),
    .Busy     (Busy),
    .Done     (Done),
    .Div_Zero (Div_Zero),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz  = 1'b0;
    e.cyc = 0;
    case (op)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (op == 2'd2) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          sq = sa / sb; sr = sa % sb;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever Done is presented.
  always @(negedge CLK) begin
    exp_t e;
    if (Reset) begin
      busy_cnt = 0;
    end else begin
      if (Busy) busy_cnt++;
      if (Div_Zero && !Done) chk("div_zero_outside_done", 64'(Div_Zero), 64'd0);
      if (Done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(Done), 64'd0);
        end else begin
          e = q.pop_front();
          chk("hi", 64'(HI), 64'(e.hi));
          chk("lo", 64'(LO), 64'(e.lo));
          chk("div_zero", 64'(Div_Zero), 64'(e.dz));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_cycles", 64'(busy_cnt), 64'd32);
          chk("busy_in_done", 64'(Busy), 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a negedge with the DUT idle or in its Done cycle.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    Start = 1'b1; Op = op; A = a; B = b;
    e = model(op, a, b);
    e.cyc = cyc + 33;
    q.push_back(e);
    @(negedge CLK);
    Start = 1'b0; Write_HI = 1'b0; Write_LO = 1'b0;
    Op = 2'($urandom); A = $urandom; B = $urandom;
  endtask

  // Returns at the negedge of the Done cycle.
  task automatic wait_done();
    int n = 0;
    while (!Done && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk("done_arrives", 64'(Done), 64'd1);
    if (!Done) q.delete();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] hold_hi, hold_lo, wv;
    bit          b2b;
    // Reset must beat a coincident Start and MTHI.
    Reset = 1'b1; Start = 1'b1; Write_HI = 1'b1; Write_LO = 1'b1; W_Data = 32'hDEAD_BEEF;
    Op = 2'd0; A = 32'd3; B = 32'd4;
    repeat (3) @(negedge CLK);
    Reset = 1'b0; Start = 1'b0; Write_HI = 1'b0; Write_LO = 1'b0;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_dz", 64'(Div_Zero), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);

    // Directed corner cases.
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(); @(negedge CLK);
    issue(2'd1, 32'hFFFF_FFFD, 32'h0000_0005); wait_done(); @(negedge CLK);
    issue(2'd3, 32'hFFFF_FFF9, 32'h0000_0002); wait_done(); @(negedge CLK);
    issue(2'd2, 32'h0000_0064, 32'h0000_0000); wait_done(); @(negedge CLK);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(); @(negedge CLK);
    issue(2'd3, 32'hFFFF_FFF9, 32'h0000_0000); wait_done(); @(negedge CLK);

    // MTHI/MTLO in idle, separately and together.
    W_Data = 32'h1234_5678; Write_HI = 1'b1;
    @(negedge CLK); Write_HI = 1'b0;
    chk("mthi_idle", 64'(HI), 64'h1234_5678);
    W_Data = 32'h0BAD_F00D; Write_HI = 1'b1; Write_LO = 1'b1;
    @(negedge CLK); Write_HI = 1'b0; Write_LO = 1'b0;
    chk("mthi_both", 64'(HI), 64'h0BAD_F00D);
    chk("mtlo_both", 64'(LO), 64'h0BAD_F00D);

    // Start and MTHI during RUN are ignored; HI/LO hide intermediate values.
    hold_hi = HI; hold_lo = LO;
    issue(2'd2, 32'd100, 32'd7);
    repeat (8) @(negedge CLK);
    Start = 1'b1; Op = 2'd0; A = 32'd9; B = 32'd9; Write_HI = 1'b1; W_Data = 32'h5555_AAAA;
    @(negedge CLK);
    Start = 1'b0; Write_HI = 1'b0;
    chk("run_hold_hi", 64'(HI), 64'(hold_hi));
    chk("run_hold_lo", 64'(LO), 64'(hold_lo));
    wait_done();

    // Back-to-back from the Done cycle; coincident MTHI is dropped.
    W_Data = 32'h7777_7777; Write_HI = 1'b1;
    issue(2'd1, 32'h8000_0000, 32'h8000_0000);
    wait_done();
    hold_hi = HI;
    W_Data = 32'hCAFE_0001; Write_LO = 1'b1;
    @(negedge CLK); Write_LO = 1'b0;
    chk("mtlo_fin", 64'(LO), 64'hCAFE_0001);
    chk("mtlo_fin_hi", 64'(HI), 64'(hold_hi));

    // Reset mid-operation aborts with no Done.
    issue(2'd0, 32'hFFFF_FFFF, 32'h0000_0003);
    repeat (9) @(negedge CLK);
    Reset = 1'b1;
    q.delete();
    @(negedge CLK);
    Reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(HI), 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    repeat (36) @(negedge CLK);
    issue(2'd0, 32'd6, 32'd7); wait_done(); @(negedge CLK);

    // Randomized operations, some back-to-back.
    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge CLK);
      issue(2'($urandom_range(0, 3)), pick(), pick());
      wait_done();
      b2b = ($urandom_range(0, 1) == 1);
    end
    repeat (3) @(negedge CLK);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_div.md
MUL_DIV -- requirements
Module: mul_div

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-002 The block SHALL use one clock, CLK; Reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock shared with the register file.
REQ-004 Reset  input  1  synchronous, active-high; clears all state.
REQ-005 Start  input  1  request to begin an operation; sampled on the rising edge of CLK.
REQ-006 Op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 A  input  32  first operand / dividend, driven from R_Data_A.
REQ-008 B  input  32  second operand / divisor, driven from R_Data_B.
REQ-009 Write_HI  input  1  MTHI strobe; loads W_Data into HI.
REQ-010 Write_LO  input  1  MTLO strobe; loads W_Data into LO.
REQ-011 W_Data  input  32  data for MTHI/MTLO.
REQ-012 Busy  output  1  high while an operation is iterating.
REQ-013 Done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-014 Div_Zero  output  1  set with Done when a division had B==0.
REQ-015 HI  output  32  product high word / remainder.
REQ-016 LO  output  32  product low word / quotient.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and FIN.
- IDLE -> RUN on Start.
- RUN -> FIN after exactly 32 iterations, tracked by a 5-bit counter.
- FIN -> IDLE, or FIN -> RUN if Start is high in FIN.
REQ-018 Start accepted on edge k SHALL give: Busy=1 for cycles k+1..k+32; HI/LO updated and Done=1 for exactly cycle k+33; Busy=0 in that cycle.
REQ-019 Op, A and B SHALL be captured only on the accepting edge; later changes SHALL NOT affect the result.
REQ-020 Start while in RUN SHALL be ignored; it SHALL NOT be queued.
REQ-021 Start during the Done cycle SHALL be accepted (back-to-back operation, same 33-cycle latency).
REQ-022 Multiplication SHALL be shift-add, one bit per cycle, producing {HI,LO} = full 64-bit product.
- MULTU treats A and B as unsigned.
- MULT treats A and B as two's complement; magnitudes are multiplied and the product is negated when the signs differ.
REQ-023 Division SHALL be restoring, one quotient bit per cycle: LO = quotient, HI = remainder.
- DIV quotient truncates toward zero; remainder sign equals dividend sign.
- DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-024 Divide with B==0 SHALL still take 33 cycles and give HI=A, LO=0xFFFFFFFF, Div_Zero=1 in the Done cycle.
REQ-025 Div_Zero SHALL be 0 in every other cycle.
REQ-026 Write_HI/Write_LO in IDLE or FIN SHALL load W_Data into HI/LO on that edge; both asserted together SHALL load both.
REQ-027 Write_HI/Write_LO while in RUN SHALL be ignored.
REQ-028 Write_HI/Write_LO on the same edge as an accepted Start SHALL be dropped; Start wins.
REQ-029 HI/LO SHALL hold their value between operations and SHALL NOT show intermediate iteration values.

Reset
REQ-030 Reset high on a rising edge SHALL force: state IDLE, counter 0, Busy=0, Done=0, Div_Zero=0, HI=0, LO=0.
REQ-031 Reset SHALL take priority over Start and Write_HI/Write_LO on the same edge.
REQ-032 Reset mid-operation SHALL abort the operation with no Done pulse and no HI/LO update.

Verification
REQ-033 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Done at k+33; HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 MULT A=0xFFFFFFFD (-3) B=0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; Busy high for exactly 32 cycles.
REQ-035 DIV A=0xFFFFFFF9 (-7) B=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, Div_Zero=0.
REQ-036 DIVU A=0x00000064 B=0 -> HI=0x00000064, LO=0xFFFFFFFF, Div_Zero=1 for the one Done cycle.
REQ-037 DIVU 100/7 started; Start with new operands and Write_HI pulsed at cycle k+10 -> both ignored; Done at k+33 with LO=0x0000000E, HI=0x00000002.
REQ-038 Reset asserted at cycle k+10 of a MULTU -> next cycle Busy=0, HI=LO=0; no Done pulse; a new Start then completes normally.
